// File: rtl/accumulator_readout.sv
// -----------------------------------------------------------------------------
// accumulator_readout
//
// Drains 16-bit signed event-sum words from the accumulator's slow-side
// first-word-fall-through FIFO and serializes them as framed bytes for the
// UART transmitter.
//
// Frame layout:
//   HEADER_BYTE, WORDS_PER_FRAME[7:0], {word[15:8], word[7:0]} x WORDS_PER_FRAME,
//   [checksum]
//
// The checksum is the 8-bit XOR of the count byte and every payload byte.
// The header is not covered. The checksum byte and its state exist only when
// the macro ACC_READOUT_CHECKSUM_EN is defined. The default build has no
// checksum: the frame ends after the last low byte.
//
// Parameters:
//   WORDS_PER_FRAME  words per frame, 1..255. It is also sent as the count byte.
//   HEADER_BYTE      first byte of every frame.
//
// Ports:
//   clk              slow-domain clock, rising edge
//   rst              asynchronous active-high reset
//   dataReadyToRead  FIFO not empty. dataIn is valid while this is high.
//   dataIn[15:0]     FIFO head word (FWFT)
//   dataRead         FIFO read strobe, one-cycle pulse per word consumed
//   txByte[7:0]      byte presented to the transmitter
//   txValid          txByte is valid. It is held until accepted.
//   txReady          transmitter accepts txByte on a rising edge with txValid
//   frameDone        one-cycle pulse after the final byte of a frame is accepted
//   busy             high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module accumulator_readout #(
  parameter int unsigned WORDS_PER_FRAME = 126,
  parameter logic [7:0]  HEADER_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dataReadyToRead,
  input  logic [15:0] dataIn,
  output logic        dataRead,
  output logic [7:0]  txByte,
  output logic        txValid,
  input  logic        txReady,
  output logic        frameDone,
  output logic        busy
);

  localparam logic [7:0] COUNT_BYTE = WORDS_PER_FRAME[7:0];
  localparam logic [7:0] LAST_IDX   = COUNT_BYTE - 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_LOAD = 3'd3,
    ST_HI   = 3'd4,
    ST_LO   = 3'd5
`ifdef ACC_READOUT_CHECKSUM_EN
    , ST_CSUM = 3'd6
`endif
  } state_t;

  state_t     state_q,      state_d;
  logic [7:0] cnt_q,        cnt_d;
  // Only the low byte of the captured word is needed later. The high byte is
  // sent directly from dataIn in the same edge that captures the word.
  logic [7:0] word_lo_q,    word_lo_d;
  logic       data_read_q,  data_read_d;
  logic [7:0] tx_byte_q,    tx_byte_d;
  logic       tx_valid_q,   tx_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q,       busy_d;
  logic       accept_s;

`ifdef ACC_READOUT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Folds one transmitted byte into the running XOR checksum.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // A byte leaves on any edge where the registered valid meets txReady.
  assign accept_s = tx_valid_q & txReady;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_lo_d    = word_lo_q;
    data_read_d  = 1'b0;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
`ifdef ACC_READOUT_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        if (dataReadyToRead) begin
          state_d    = ST_HDR;
          tx_byte_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
          cnt_d      = 8'd0;
`ifdef ACC_READOUT_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HDR: begin
        if (accept_s) begin
          state_d   = ST_CNT;
          tx_byte_d = COUNT_BYTE;
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_CNT: begin
        if (accept_s) begin
          state_d    = ST_LOAD;
          tx_valid_d = 1'b0;
`ifdef ACC_READOUT_CHECKSUM_EN
          csum_d     = csum_fold(csum_q, tx_byte_q);
`endif
        end else begin
          state_d = ST_CNT;
        end
      end

      ST_LOAD: begin
        tx_valid_d = 1'b0;
        if (dataReadyToRead) begin
          // The strobe is registered, so the FIFO pops at the end of HI's
          // first cycle. The next head word is then ready before LOAD returns.
          state_d     = ST_HI;
          word_lo_d   = dataIn[7:0];
          tx_byte_d   = dataIn[15:8];
          tx_valid_d  = 1'b1;
          data_read_d = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_HI: begin
        if (accept_s) begin
          state_d   = ST_LO;
          tx_byte_d = word_lo_q;
`ifdef ACC_READOUT_CHECKSUM_EN
          csum_d    = csum_fold(csum_q, tx_byte_q);
`endif
        end else begin
          state_d = ST_HI;
        end
      end

      ST_LO: begin
        if (accept_s) begin
`ifdef ACC_READOUT_CHECKSUM_EN
          csum_d = csum_fold(csum_q, tx_byte_q);
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef ACC_READOUT_CHECKSUM_EN
            // The checksum byte is the fold of the last low byte. It is
            // presented back-to-back, so txValid stays high.
            state_d   = ST_CSUM;
            tx_byte_d = csum_fold(csum_q, tx_byte_q);
`else
            state_d      = ST_IDLE;
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
`endif
          end else begin
            state_d    = ST_LOAD;
            tx_valid_d = 1'b0;
            cnt_d      = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_LO;
        end
      end

`ifdef ACC_READOUT_CHECKSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          state_d      = ST_IDLE;
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif

      default: begin
        // An unreachable encoding recovers to IDLE with nothing presented.
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      word_lo_q    <= 8'h00;
      data_read_q  <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ACC_READOUT_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_lo_q    <= word_lo_d;
      data_read_q  <= data_read_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef ACC_READOUT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign dataRead  = data_read_q;
  assign txByte    = tx_byte_q;
  assign txValid   = tx_valid_q;
  assign frameDone = frame_done_q;
  assign busy      = busy_q;

endmodule
